// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 set-2 scan-code decoder tracking held game keys
module ps2_key_tracker #(
    parameter int TIMEOUT_CYCLES = 250000,
    parameter int E1_SKIP_BYTES  = 7
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_byte_en,
    input  logic       flush,
    output logic [7:0] kbData,
    output logic       kbExt,
    output logic [4:0] key_held,
    output logic [4:0] key_press,
    output logic       seq_error
);

    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SKIP_W = $clog2(E1_SKIP_BYTES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SKIP_W-1:0] SKIP_START = SKIP_W'(E1_SKIP_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_SKIP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [7:0]        kb_data_q, kb_data_d;
    logic              kb_ext_q, kb_ext_d;
    logic [4:0]        held_q, held_d;
    logic [4:0]        press_q, press_d;
    logic              err_q, err_d;

    logic              do_make;
    logic              do_brk;
    logic              code_ext;
    logic [4:0]        act;

    // Action bit for a code: {back, view, pause, play, jump}
    function automatic logic [4:0] action_of(input logic [7:0] c, input logic e);
        logic [4:0] a;
        a = '0;
        if (!e) begin
            case (c)
                8'h29, 8'h1D: a[0] = 1'b1;
                8'h5A:        a[1] = 1'b1;
                8'h4D:        a[2] = 1'b1;
                8'h1B:        a[3] = 1'b1;
                8'h76:        a[4] = 1'b1;
                default:      a    = '0;
            endcase
        end else begin
            case (c)
                8'h75:   a[0] = 1'b1;
                8'h5A:   a[1] = 1'b1;
                default: a    = '0;
            endcase
        end
        return a;
    endfunction

    // Controller responses and self-test bytes that carry no key information
    function automatic logic is_ignored(input logic [7:0] c);
        return (c == 8'h00) || (c == 8'hAA) || (c == 8'hEE) || (c == 8'hFA) ||
               (c == 8'hFC) || (c == 8'hFE) || (c == 8'hFF);
    endfunction

    // State and output registers
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            skip_q    <= '0;
            kb_data_q <= 8'h00;
            kb_ext_q  <= 1'b0;
            held_q    <= '0;
            press_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            skip_q    <= skip_d;
            kb_data_q <= kb_data_d;
            kb_ext_q  <= kb_ext_d;
            held_q    <= held_d;
            press_q   <= press_d;
            err_q     <= err_d;
        end
    end

    // Sequence decode, prefix timeout and key bookkeeping
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        skip_d    = skip_q;
        kb_data_d = kb_data_q;
        kb_ext_d  = kb_ext_q;
        held_d    = held_q;
        press_d   = '0;
        err_d     = 1'b0;
        do_make   = 1'b0;
        do_brk    = 1'b0;
        code_ext  = 1'b0;

        if (flush) begin
            // Game reset drops any coincident byte and all held keys
            state_d   = S_IDLE;
            cnt_d     = '0;
            skip_d    = '0;
            kb_data_d = 8'h00;
            kb_ext_d  = 1'b0;
            held_d    = '0;
        end else if (ps2_byte_en) begin
            // A byte always wins over an expiring timeout
            cnt_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (ps2_byte == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (ps2_byte == 8'hF0) begin
                        state_d = S_BRK;
                    end else if (ps2_byte == 8'hE1) begin
                        state_d = S_SKIP;
                        skip_d  = SKIP_START;
                    end else if (!is_ignored(ps2_byte)) begin
                        do_make = 1'b1;
                    end
                end
                S_EXT: begin
                    if (ps2_byte == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else begin
                        do_make  = 1'b1;
                        code_ext = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                S_BRK: begin
                    do_brk  = 1'b1;
                    state_d = S_IDLE;
                end
                S_EXT_BRK: begin
                    do_brk   = 1'b1;
                    code_ext = 1'b1;
                    state_d  = S_IDLE;
                end
                S_SKIP: begin
                    if (skip_q <= SKIP_W'(1)) begin
                        skip_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        skip_d = skip_q - SKIP_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            // Mid-sequence silence: abort once the gap reaches the limit
            if (cnt_q == CNT_LAST) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                skip_d  = '0;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end

        act = action_of(ps2_byte, code_ext);

        if (do_make) begin
            kb_data_d = ps2_byte;
            kb_ext_d  = code_ext;
            held_d    = held_q | act;
            press_d   = act & ~held_q;
        end

        if (do_brk) begin
            held_d = held_q & ~act;
            // Only the release of the newest key clears kbData
            if ((kb_data_q == ps2_byte) && (kb_ext_q == code_ext)) begin
                kb_data_d = 8'h00;
                kb_ext_d  = 1'b0;
            end
        end
    end

    assign kbData    = kb_data_q;
    assign kbExt     = kb_ext_q;
    assign key_held  = held_q;
    assign key_press = press_q;
    assign seq_error = err_q;

endmodule
